// File: rtl/fejkon_pcie_pkg.sv
// Shared TLP streaming widths, beat record and TX arbiter state encoding.
// Pure definitions: no latency, no flow control.
package fejkon_pcie_pkg;

  localparam int TLP_DATA_W  = 256;
  localparam int TLP_EMPTY_W = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_CPL = 2'd1,
    GRANT_DMA = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [TLP_DATA_W-1:0]  data;
    logic [TLP_EMPTY_W-1:0] empty;
    logic                   sop;
    logic                   eop;
  } st_beat_t;

endpackage

// File: rtl/fejkon_st_pipe_reg.sv
// One-deep Avalon-ST register stage: 1-cycle latency, holds its beat while the
// sink stalls; in_ready = down_ready | ~out_valid so a consumed slot refills same cycle.
module fejkon_st_pipe_reg
  import fejkon_pcie_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  input  st_beat_t in_beat,
  output logic     in_ready,
  output logic     out_valid,
  output st_beat_t out_beat,
  input  logic     down_ready
);

  assign in_ready = down_ready | ~out_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_beat <= in_beat;
    end
  end

endmodule

// File: rtl/fejkon_pcie_tx_arb.sv
// Packet-atomic arbiter merging completion and DMA TLP streams onto the hard IP TX port.
// One register stage of latency; granted sink sees output-stage ready, ungranted sink stalls.
module fejkon_pcie_tx_arb
  import fejkon_pcie_pkg::*;
#(
  parameter int CPL_PRIORITY = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TLP_DATA_W-1:0]  cpl_data,
  input  logic                   cpl_startofpacket,
  input  logic                   cpl_endofpacket,
  input  logic [TLP_EMPTY_W-1:0] cpl_empty,
  input  logic                   cpl_valid,
  output logic                   cpl_ready,
  input  logic [TLP_DATA_W-1:0]  dma_data,
  input  logic                   dma_startofpacket,
  input  logic                   dma_endofpacket,
  input  logic [TLP_EMPTY_W-1:0] dma_empty,
  input  logic                   dma_valid,
  output logic                   dma_ready,
  output logic [TLP_DATA_W-1:0]  tx_st_data,
  output logic                   tx_st_startofpacket,
  output logic                   tx_st_endofpacket,
  output logic [TLP_EMPTY_W-1:0] tx_st_empty,
  output logic                   tx_st_valid,
  output logic                   tx_st_error,
  input  logic                   tx_st_ready,
  output logic [31:0]            cnt_cpl_pkts,
  output logic [31:0]            cnt_dma_pkts,
  output logic [31:0]            cnt_drop_beats
);

  arb_state_e state;
  logic       last_dma;
  logic       out_ready;
  logic       cpl_req, dma_req, cpl_drop, dma_drop, pick_cpl, pick_dma;
  logic       cpl_take, dma_take, cpl_fwd, dma_fwd;
  logic [1:0] drop_inc;
  st_beat_t   cpl_beat, dma_beat, fwd_beat, out_beat;

  assign cpl_beat = {cpl_data, cpl_empty, cpl_startofpacket, cpl_endofpacket};
  assign dma_beat = {dma_data, dma_empty, dma_startofpacket, dma_endofpacket};

  always_comb begin
    cpl_req  = cpl_valid & cpl_startofpacket;
    dma_req  = dma_valid & dma_startofpacket;
    cpl_drop = cpl_valid & ~cpl_startofpacket;
    dma_drop = dma_valid & ~dma_startofpacket;
    // last_dma starts at 1 so the first round-robin tie goes to completions
    pick_cpl = cpl_req & (~dma_req | (CPL_PRIORITY != 0) | last_dma);
    pick_dma = dma_req & ~pick_cpl;
    cpl_ready = 1'b0;
    dma_ready = 1'b0;
    case (state)
      IDLE: begin
        cpl_ready = cpl_drop | (pick_cpl & out_ready);
        dma_ready = dma_drop | (pick_dma & out_ready);
      end
      GRANT_CPL: cpl_ready = out_ready;
      GRANT_DMA: dma_ready = out_ready;
      default: ;
    endcase
    if (reset) begin
      cpl_ready = 1'b0;
      dma_ready = 1'b0;
    end
    cpl_take = cpl_valid & cpl_ready;
    dma_take = dma_valid & dma_ready;
    // in IDLE only a start-of-packet beat is forwarded; anything else is discarded
    cpl_fwd  = cpl_take & ((state != IDLE) | cpl_startofpacket);
    dma_fwd  = dma_take & ((state != IDLE) | dma_startofpacket);
    drop_inc = {1'b0, cpl_take & ~cpl_fwd} + {1'b0, dma_take & ~dma_fwd};
    fwd_beat = dma_fwd ? dma_beat : cpl_beat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_dma       <= 1'b1;
      cnt_cpl_pkts   <= '0;
      cnt_dma_pkts   <= '0;
      cnt_drop_beats <= '0;
    end else begin
      cnt_drop_beats <= cnt_drop_beats + {30'd0, drop_inc};
      if (cpl_fwd & cpl_endofpacket) cnt_cpl_pkts <= cnt_cpl_pkts + 32'd1;
      if (dma_fwd & dma_endofpacket) cnt_dma_pkts <= cnt_dma_pkts + 32'd1;
      case (state)
        IDLE: begin
          if (cpl_fwd) begin
            last_dma <= 1'b0;
            if (!cpl_endofpacket) state <= GRANT_CPL;
          end else if (dma_fwd) begin
            last_dma <= 1'b1;
            if (!dma_endofpacket) state <= GRANT_DMA;
          end
        end
        GRANT_CPL: if (cpl_fwd & cpl_endofpacket) state <= IDLE;
        GRANT_DMA: if (dma_fwd & dma_endofpacket) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  fejkon_st_pipe_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (cpl_fwd | dma_fwd),
    .in_beat   (fwd_beat),
    .in_ready  (out_ready),
    .out_valid (tx_st_valid),
    .out_beat  (out_beat),
    .down_ready(tx_st_ready)
  );

  assign tx_st_data          = out_beat.data;
  assign tx_st_empty         = out_beat.empty;
  assign tx_st_startofpacket = out_beat.sop;
  assign tx_st_endofpacket   = out_beat.eop;
  assign tx_st_error         = 1'b0;

endmodule

// File: tb/tb_fejkon_pcie_tx_arb.sv
// Bench for fejkon_pcie_tx_arb: round-robin (u_rr) and completion-priority (u_pri)
// instances, table vectors, directed corner sequences and a randomized scoreboard run.
module tb_fejkon_pcie_tx_arb;

  typedef struct packed {
    logic [255:0] data;
    logic [1:0]   empty;
    logic         sop;
    logic         eop;
  } beat_t;

  typedef struct {
    int inst;
    bit cv, cs, dv, ds;
    bit exp_cr, exp_dr;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] cpl_data [2];
  logic         cpl_sop [2], cpl_eop [2], cpl_valid [2], cpl_ready [2];
  logic [1:0]   cpl_empty [2];
  logic [255:0] dma_data [2];
  logic         dma_sop [2], dma_eop [2], dma_valid [2], dma_ready [2];
  logic [1:0]   dma_empty [2];
  logic [255:0] tx_data [2];
  logic         tx_sop [2], tx_eop [2], tx_valid [2], tx_error [2], tx_ready [2];
  logic [1:0]   tx_empty [2];
  logic [31:0]  cnt_cpl [2], cnt_dma [2], cnt_drop [2];

  int    checks = 0;
  int    failures = 0;
  beat_t cq[$], dq[$], olog[$];

  always #5 clk = ~clk;

  fejkon_pcie_tx_arb #(.CPL_PRIORITY(0)) u_rr (
    .clk(clk), .reset(reset),
    .cpl_data(cpl_data[0]), .cpl_startofpacket(cpl_sop[0]), .cpl_endofpacket(cpl_eop[0]),
    .cpl_empty(cpl_empty[0]), .cpl_valid(cpl_valid[0]), .cpl_ready(cpl_ready[0]),
    .dma_data(dma_data[0]), .dma_startofpacket(dma_sop[0]), .dma_endofpacket(dma_eop[0]),
    .dma_empty(dma_empty[0]), .dma_valid(dma_valid[0]), .dma_ready(dma_ready[0]),
    .tx_st_data(tx_data[0]), .tx_st_startofpacket(tx_sop[0]), .tx_st_endofpacket(tx_eop[0]),
    .tx_st_empty(tx_empty[0]), .tx_st_valid(tx_valid[0]), .tx_st_error(tx_error[0]),
    .tx_st_ready(tx_ready[0]),
    .cnt_cpl_pkts(cnt_cpl[0]), .cnt_dma_pkts(cnt_dma[0]), .cnt_drop_beats(cnt_drop[0])
  );

  fejkon_pcie_tx_arb #(.CPL_PRIORITY(1)) u_pri (
    .clk(clk), .reset(reset),
    .cpl_data(cpl_data[1]), .cpl_startofpacket(cpl_sop[1]), .cpl_endofpacket(cpl_eop[1]),
    .cpl_empty(cpl_empty[1]), .cpl_valid(cpl_valid[1]), .cpl_ready(cpl_ready[1]),
    .dma_data(dma_data[1]), .dma_startofpacket(dma_sop[1]), .dma_endofpacket(dma_eop[1]),
    .dma_empty(dma_empty[1]), .dma_valid(dma_valid[1]), .dma_ready(dma_ready[1]),
    .tx_st_data(tx_data[1]), .tx_st_startofpacket(tx_sop[1]), .tx_st_endofpacket(tx_eop[1]),
    .tx_st_empty(tx_empty[1]), .tx_st_valid(tx_valid[1]), .tx_st_error(tx_error[1]),
    .tx_st_ready(tx_ready[1]),
    .cnt_cpl_pkts(cnt_cpl[1]), .cnt_dma_pkts(cnt_dma[1]), .cnt_drop_beats(cnt_drop[1])
  );

  task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input bit is_dma, input bit v, input beat_t b);
    if (is_dma) begin
      dma_valid[i] = v; dma_data[i] = b.data; dma_empty[i] = b.empty;
      dma_sop[i] = b.sop; dma_eop[i] = b.eop;
    end else begin
      cpl_valid[i] = v; cpl_data[i] = b.data; cpl_empty[i] = b.empty;
      cpl_sop[i] = b.sop; cpl_eop[i] = b.eop;
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 1'b0, '0);
      drive(i, 1'b1, 1'b0, '0);
      tx_ready[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic add_pkt(input bit is_dma, input int nb, input int seq);
    beat_t b;
    for (int j = 0; j < nb; j++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b.data[255:248] = is_dma ? 8'd2 : 8'd1;
      b.data[15:0] = 16'(seq);
      b.data[23:16] = 8'(j);
      b.empty = 2'($urandom_range(3));
      b.sop = (j == 0);
      b.eop = (j == nb - 1);
      if (is_dma) dq.push_back(b); else cq.push_back(b);
    end
  endtask

  task automatic add_junk(input bit is_dma);
    beat_t b;
    b = '0;
    b.data = {8{$urandom}};
    if (is_dma) dq.push_back(b); else cq.push_back(b);
  endtask

  // Reference: packets are atomic, ties resolved by rule, output is a 1-entry queue.
  task automatic run(input int i, input int maxcyc, input int vpct, input int rpct);
    int    owner, own0, ncpl, ndma, ndrop;
    bit    last_dma, cv, dv, tr, ordy, creq, dreq, pc, pd, ecr, edr;
    beat_t oq[$];
    beat_t b, obs;
    owner = 0; last_dma = 1'b1; ncpl = 0; ndma = 0; ndrop = 0;
    olog.delete();
    for (int cyc = 0; cyc < maxcyc && (cq.size() + dq.size() + oq.size()) > 0; cyc++) begin
      cv = (cq.size() > 0) && ($urandom_range(99) < vpct);
      dv = (dq.size() > 0) && ($urandom_range(99) < vpct);
      tr = ($urandom_range(99) < rpct);
      b = '0; if (cv) b = cq[0]; drive(i, 1'b0, cv, b);
      b = '0; if (dv) b = dq[0]; drive(i, 1'b1, dv, b);
      tx_ready[i] = tr;
      @(negedge clk);
      ordy = (oq.size() == 0) || tr;
      creq = cv && cq[0].sop;
      dreq = dv && dq[0].sop;
      if (owner == 0) begin
        pc  = creq && (!dreq || i == 1 || last_dma);
        pd  = dreq && !pc;
        ecr = (cv && !cq[0].sop) || (pc && ordy);
        edr = (dv && !dq[0].sop) || (pd && ordy);
      end else begin
        ecr = (owner == 1) && ordy;
        edr = (owner == 2) && ordy;
      end
      chk("run_cpl_ready", cpl_ready[i], ecr);
      chk("run_dma_ready", dma_ready[i], edr);
      chk("run_tx_valid", tx_valid[i], oq.size() != 0);
      obs = {tx_data[i], tx_empty[i], tx_sop[i], tx_eop[i]};
      if (oq.size() != 0) chk("run_tx_beat", obs, oq[0]);
      if (tx_valid[i] && tr) olog.push_back(obs);
      if (oq.size() != 0 && tr) void'(oq.pop_front());
      own0 = owner;
      if (cv && ecr) begin
        b = cq.pop_front();
        if (own0 == 0 && !b.sop) ndrop++;
        else begin
          oq.push_back(b);
          if (own0 == 0) last_dma = 1'b0;
          owner = b.eop ? 0 : 1;
          if (b.eop) ncpl++;
        end
      end
      if (dv && edr) begin
        b = dq.pop_front();
        if (own0 == 0 && !b.sop) ndrop++;
        else begin
          oq.push_back(b);
          if (own0 == 0) last_dma = 1'b1;
          owner = b.eop ? 0 : 2;
          if (b.eop) ndma++;
        end
      end
      @(posedge clk);
      #1;
    end
    drive(i, 1'b0, 1'b0, '0);
    drive(i, 1'b1, 1'b0, '0);
    chk("run_drain_in_budget", cq.size() + dq.size() + oq.size(), 0);
    chk("run_cnt_cpl", cnt_cpl[i], ncpl);
    chk("run_cnt_dma", cnt_dma[i], ndma);
    chk("run_cnt_drop", cnt_drop[i], ndrop);
  endtask

  task automatic chk_order(input string name, input int exp_ports[$]);
    int sops[$];
    foreach (olog[k]) if (olog[k].sop) sops.push_back(int'(olog[k].data[255:248]));
    chk({name, "_npkts"}, sops.size(), exp_ports.size());
    foreach (exp_ports[k]) if (k < sops.size()) chk({name, "_port"}, sops[k], exp_ports[k]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[9];
    beat_t b;
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 1, 0, 0, 1, 0};
    vecs[2] = '{0, 0, 0, 1, 1, 0, 1};
    vecs[3] = '{0, 1, 1, 1, 1, 1, 0};
    vecs[4] = '{0, 1, 0, 0, 0, 1, 0};
    vecs[5] = '{0, 1, 0, 1, 1, 1, 1};
    vecs[6] = '{0, 1, 1, 1, 0, 1, 1};
    vecs[7] = '{1, 1, 1, 1, 1, 1, 0};
    vecs[8] = '{1, 0, 0, 1, 0, 0, 1};

    // reset state, with requests pending to show readies are held low
    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      cpl_valid[i] = 1'b1; cpl_sop[i] = 1'b1; tx_ready[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_cpl_ready", cpl_ready[i], 0);
      chk("rst_dma_ready", dma_ready[i], 0);
      chk("rst_tx_valid", tx_valid[i], 0);
      chk("rst_tx_sop_eop", {tx_sop[i], tx_eop[i]}, 0);
      chk("rst_tx_data_empty", {tx_data[i], tx_empty[i]}, 0);
      chk("rst_counters", {cnt_cpl[i], cnt_dma[i], cnt_drop[i]}, 0);
      chk("tx_error", tx_error[i], 0);
    end
    clear_inputs();
    reset = 1'b0;

    // IDLE ready decisions straight out of reset
    for (int k = 0; k < 9; k++) begin
      clear_inputs();
      cpl_valid[vecs[k].inst] = vecs[k].cv; cpl_sop[vecs[k].inst] = vecs[k].cs;
      dma_valid[vecs[k].inst] = vecs[k].dv; dma_sop[vecs[k].inst] = vecs[k].ds;
      #1;
      chk($sformatf("vec%0d_cpl_ready", k), cpl_ready[vecs[k].inst], vecs[k].exp_cr);
      chk($sformatf("vec%0d_dma_ready", k), dma_ready[vecs[k].inst], vecs[k].exp_dr);
    end
    clear_inputs();
    @(posedge clk);
    #1;

    // single-beat completion
    b.data = {32{8'hA5}}; b.empty = 2'd1; b.sop = 1'b1; b.eop = 1'b1;
    drive(0, 1'b0, 1'b1, b);
    @(negedge clk);
    chk("single_cpl_ready", cpl_ready[0], 1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, '0);
    chk("single_tx_valid", tx_valid[0], 1);
    chk("single_tx_data", tx_data[0], {32{8'hA5}});
    chk("single_tx_empty", tx_empty[0], 1);
    chk("single_tx_sop_eop", {tx_sop[0], tx_eop[0]}, 2'b11);
    chk("single_cnt_cpl", cnt_cpl[0], 1);
    tx_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("single_tx_cleared", tx_valid[0], 0);

    // DMA beat without sop in IDLE is discarded
    b = '0; b.data = {8{32'hDEAD_BEEF}};
    drive(0, 1'b1, 1'b1, b);
    @(negedge clk);
    chk("drop_dma_ready", dma_ready[0], 1);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("drop_no_tx_valid", tx_valid[0], 0);
    chk("drop_cnt", cnt_drop[0], 1);

    // output stall in the middle of a DMA packet
    do_reset();
    cq.delete(); dq.delete();
    add_pkt(1'b1, 3, 7);
    drive(0, 1'b1, 1'b1, dq[0]);
    tx_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b1, dq[1]);
    tx_ready[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_dma_ready", dma_ready[0], 0);
      chk("stall_tx_valid", tx_valid[0], 1);
      chk("stall_tx_data", tx_data[0], dq[0].data);
      @(posedge clk);
      #1;
    end
    tx_ready[0] = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", dma_ready[0], 1);
    @(posedge clk);
    #1;
    chk("stall_beat1", tx_data[0], dq[1].data);
    drive(0, 1'b1, 1'b1, dq[2]);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, '0);
    chk("stall_beat2", {tx_data[0], tx_eop[0]}, {dq[2].data, 1'b1});
    @(posedge clk);
    #1;
    chk("stall_tx_done", tx_valid[0], 0);
    chk("stall_cnt_dma", cnt_dma[0], 1);

    // simultaneous requests, round robin, 3-beat packets
    do_reset();
    cq.delete(); dq.delete();
    add_pkt(1'b0, 3, 1); add_pkt(1'b0, 3, 2);
    add_pkt(1'b1, 3, 1); add_pkt(1'b1, 3, 2);
    run(0, 200, 100, 100);
    chk("rr_beats", olog.size(), 12);
    chk_order("rr_order", '{1, 2, 1, 2});

    // completion priority with both ports continuously requesting
    do_reset();
    cq.delete(); dq.delete();
    for (int k = 0; k < 3; k++) add_pkt(1'b0, 2, k);
    for (int k = 0; k < 2; k++) add_pkt(1'b1, 2, k);
    run(1, 200, 100, 100);
    chk_order("pri_order", '{1, 1, 1, 2, 2});

    // reset on beat 2 of a 4-beat completion, then a clean DMA packet
    do_reset();
    cq.delete(); dq.delete();
    add_pkt(1'b0, 4, 3);
    tx_ready[0] = 1'b1;
    drive(0, 1'b0, 1'b1, cq[0]);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, cq[1]);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, cq[2]);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cpl_ready", cpl_ready[0], 0);
    @(posedge clk);
    #1;
    chk("midrst_tx_valid", tx_valid[0], 0);
    chk("midrst_tx_sop_eop", {tx_sop[0], tx_eop[0]}, 0);
    chk("midrst_tx_data_empty", {tx_data[0], tx_empty[0]}, 0);
    chk("midrst_counters", {cnt_cpl[0], cnt_dma[0], cnt_drop[0]}, 0);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0);
    cq.delete(); dq.delete();
    add_pkt(1'b1, 2, 9);
    run(0, 100, 100, 100);
    chk("midrst_after_beats", olog.size(), 2);
    chk_order("midrst_after_order", '{2});

    // randomized traffic with junk beats and backpressure on both variants
    for (int i = 0; i < 2; i++) begin
      do_reset();
      cq.delete(); dq.delete();
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(9) == 0) add_junk(1'($urandom_range(1)));
        else add_pkt(1'($urandom_range(1)), int'($urandom_range(1, 4)), n);
      end
      run(i, 4000, 70, 65);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fejkon_pcie_tx_arb.md
FEJKON_PCIE_TX_ARB -- requirements
Module: fejkon_pcie_tx_arb

Interface
REQ-001 Parameter CPL_PRIORITY, default 0; 0 = round-robin between requesters, 1 = completion port strictly preferred.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 cpl_data/cpl_startofpacket/cpl_endofpacket/cpl_empty/cpl_valid  in  256/1/1/2/1  completion TLP sink (Avalon-ST, ready latency 0).
REQ-005 cpl_ready  out  1  completion sink ready.
REQ-006 dma_data/dma_startofpacket/dma_endofpacket/dma_empty/dma_valid  in  256/1/1/2/1  DMA write TLP sink (Avalon-ST, ready latency 0).
REQ-007 dma_ready  out  1  DMA sink ready.
REQ-008 tx_st_data/tx_st_startofpacket/tx_st_endofpacket/tx_st_empty/tx_st_valid  out  256/1/1/2/1  merged TLP source to hard IP.
REQ-009 tx_st_error  out  1  tied 0.
REQ-010 tx_st_ready  in  1  hard IP ready (ready latency 0 at this boundary).
REQ-011 cnt_cpl_pkts, cnt_dma_pkts, cnt_drop_beats  out  32 each  statistics.

Function
REQ-012 FSM states IDLE, GRANT_CPL, GRANT_DMA; state encoding is an enum.
REQ-013 IDLE: grant goes to a port presenting valid & startofpacket; if both, CPL_PRIORITY=1 picks cpl, else the port not granted last (initial last = dma, so cpl wins first tie).
REQ-014 Grant decision and first-beat transfer occur in the same cycle; no idle bubble between grant and first beat.
REQ-015 Grant held until the granted port's endofpacket beat is accepted; then FSM returns to IDLE and the new packet may be granted on the following cycle.
REQ-016 Ungranted port ready is 0; granted port ready = out_ready, where out_ready = tx_st_ready | ~tx_st_valid.
REQ-017 Output is one register stage: accepted beat appears on tx_st_* exactly 1 cycle after acceptance; beats are never interleaved between packets.
REQ-018 tx_st_* holds value while tx_st_valid & ~tx_st_ready; tx_st_valid clears when beat consumed and no new beat accepted.
REQ-019 In IDLE, a valid beat without startofpacket on either port is accepted and discarded (ready=1 for that port); cnt_drop_beats increments per beat.
REQ-020 Single-beat packet (sop & eop together) is granted, forwarded and released in one accept cycle.
REQ-021 cnt_cpl_pkts/cnt_dma_pkts increment on acceptance of an endofpacket beat from that port; all counters wrap 2^32-1 -> 0.
REQ-022 Data, empty, sop, eop forwarded unmodified; no reordering within a port.

Reset
REQ-023 During reset: state = IDLE, last grant = dma, tx_st_valid/sop/eop = 0, tx_st_empty = 0, tx_st_data = 0, cpl_ready = dma_ready = 0, all counters = 0.
REQ-024 Reset mid-packet abandons the packet: output beat dropped, no eop generated; next packet after reset starts cleanly.

Structure
REQ-025 Shared package fejkon_pcie_pkg holds TLP_DATA_W=256, TLP_EMPTY_W=2 and the arbiter state enum.
REQ-026 One sub-module, fejkon_st_pipe_reg (256+4-bit Avalon-ST register stage with out_ready logic), instantiated once for the output.

Verification
REQ-027 Single-beat cpl (data 0xA5..A5, empty 1) alone -> tx_st_valid next cycle, same data/empty, cnt_cpl_pkts=1.
REQ-028 Both ports assert sop same cycle, CPL_PRIORITY=0, 3-beat packets -> cpl packet fully out, then dma, then next tie goes cpl; no interleave.
REQ-029 tx_st_ready low 5 cycles mid dma packet -> tx_st_* stable, dma_ready=0, no beat lost or duplicated.
REQ-030 dma beat valid without sop in IDLE -> beat consumed, no tx_st_valid, cnt_drop_beats=1.
REQ-031 reset asserted on beat 2 of 4-beat cpl packet -> all outputs at reset values next cycle; subsequent dma packet forwarded intact.
REQ-032 CPL_PRIORITY=1, dma and cpl continuously valid -> only cpl packets granted while cpl holds sop pending.
